// File: rtl/dct_block_scheduler.sv
// Ping-pong scheduler between the pixel loader and the 8x8 DCT over two 64-byte block buffers.
// Write-side outputs are combinational; dct_start appears 2 cycles after a buffer fills; wr_ready drops while the target buffer is not EMPTY.
module dct_block_scheduler #(
    parameter int BLOCKS_PER_FRAME = 1200,
    parameter int CNT_WIDTH        = 11
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic                 wr_valid,
    input  logic [7:0]           wr_data,
    output logic                 wr_ready,
    output logic [1:0]           buf_we,
    output logic [5:0]           buf_waddr,
    output logic [7:0]           buf_wdata,
    output logic                 dct_start,
    output logic                 dct_buf_sel,
    input  logic                 dct_done,
    output logic [CNT_WIDTH-1:0] blocks_written,
    output logic [CNT_WIDTH-1:0] blocks_done,
    output logic                 frame_done,
    output logic                 busy
);

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {EMPTY, FULL, BUSY} buf_state_t;

    localparam logic [CNT_WIDTH-1:0] BLK_TOTAL = CNT_WIDTH'(BLOCKS_PER_FRAME);
    localparam logic [CNT_WIDTH-1:0] BLK_LAST  = CNT_WIDTH'(BLOCKS_PER_FRAME - 1);

    state_t     state_q, state_d;
    buf_state_t buf_st [2];
    logic       wsel, rsel, outstanding;
    logic [5:0] wr_addr;

    logic run, accept, launch, retire, last_retire, start_frame;

    assign run         = (state_q == RUN);
    assign start_frame = (state_q == IDLE) && frame_start;
    // The outstanding flag keeps a launch and a retire from ever sharing a cycle.
    assign launch      = run && !outstanding && (buf_st[rsel] == FULL);
    assign retire      = run && outstanding && dct_done;
    assign last_retire = retire && (blocks_done == BLK_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_start) state_d = RUN;
            RUN:     if (last_retire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ready  = run && (buf_st[wsel] == EMPTY) && (blocks_written < BLK_TOTAL);
        accept    = wr_valid && wr_ready;
        buf_we    = 2'b00;
        if (accept) buf_we = wsel ? 2'b10 : 2'b01;
        buf_waddr = wr_addr;
        buf_wdata = wr_data;
        busy      = run;
    end

    // Write, launch and retire always touch different buffers, so their updates never collide.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_st[0]      <= EMPTY;
            buf_st[1]      <= EMPTY;
            wsel           <= 1'b0;
            rsel           <= 1'b0;
            outstanding    <= 1'b0;
            wr_addr        <= '0;
            dct_start      <= 1'b0;
            dct_buf_sel    <= 1'b0;
            frame_done     <= 1'b0;
            blocks_written <= '0;
            blocks_done    <= '0;
        end else begin
            dct_start  <= launch;
            frame_done <= last_retire;
            if (start_frame) begin
                buf_st[0]      <= EMPTY;
                buf_st[1]      <= EMPTY;
                wsel           <= 1'b0;
                rsel           <= 1'b0;
                outstanding    <= 1'b0;
                wr_addr        <= '0;
                blocks_written <= '0;
                blocks_done    <= '0;
            end else begin
                if (accept) begin
                    wr_addr <= wr_addr + 6'd1;
                    if (wr_addr == 6'd63) begin
                        buf_st[wsel]   <= FULL;
                        wsel           <= ~wsel;
                        blocks_written <= blocks_written + 1'b1;
                    end
                end
                if (launch) begin
                    buf_st[rsel] <= BUSY;
                    dct_buf_sel  <= rsel;
                    outstanding  <= 1'b1;
                end
                if (retire) begin
                    buf_st[rsel] <= EMPTY;
                    rsel         <= ~rsel;
                    outstanding  <= 1'b0;
                    blocks_done  <= blocks_done + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dct_block_scheduler.sv
// Scoreboard bench for dct_block_scheduler with a 3-block frame; stimulus queues expected writes/launches/frame ends, a monitor pops them.
module tb_dct_block_scheduler;

    localparam int BPF = 3;
    localparam int CW  = 11;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          frame_start = 1'b0;
    logic          wr_valid = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          wr_ready;
    logic [1:0]    buf_we;
    logic [5:0]    buf_waddr;
    logic [7:0]    buf_wdata;
    logic          dct_start;
    logic          dct_buf_sel;
    logic          dct_done;
    logic [CW-1:0] blocks_written;
    logic [CW-1:0] blocks_done;
    logic          frame_done;
    logic          busy;

    logic manual_done = 1'b0;
    logic model_done  = 1'b0;
    assign dct_done = manual_done | model_done;

    dct_block_scheduler #(.BLOCKS_PER_FRAME(BPF), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .frame_start(frame_start),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
        .dct_start(dct_start), .dct_buf_sel(dct_buf_sel), .dct_done(dct_done),
        .blocks_written(blocks_written), .blocks_done(blocks_done),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int errors   = 0;
    int launches = 0;
    int mcount   = 0;
    bit auto_dct = 1'b0;
    bit rand_lat = 1'b0;

    logic [15:0] wq [$];   // {buf_we, buf_waddr, buf_wdata}
    bit          lq [$];   // expected dct_buf_sel per launch
    bit          fq [$];   // one entry per expected frame_done

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents a write, a launch or a frame end.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (buf_we != 2'b00) begin
                    if (wq.size() == 0) chk("unexpected_write", 32'({buf_we, buf_waddr, buf_wdata}), 32'hFFFFFFFF);
                    else begin
                        e = wq.pop_front();
                        chk("write", 32'({buf_we, buf_waddr, buf_wdata}), 32'(e));
                    end
                end
                if (dct_start) begin
                    launches++;
                    if (lq.size() == 0) chk("unexpected_dct_start", 32'(dct_buf_sel), 32'hFFFFFFFF);
                    else chk("dct_buf_sel", 32'(dct_buf_sel), 32'(lq.pop_front()));
                end
                if (frame_done) begin
                    if (fq.size() == 0) chk("unexpected_frame_done", 32'(frame_done), 32'h0);
                    else begin
                        void'(fq.pop_front());
                        chk("frame_done", 32'(frame_done), 32'h1);
                    end
                end
            end
        end
    end

    // DCT model: answers each dct_start after a fixed or random latency.
    initial begin
        int lat;
        forever begin
            @(negedge clock);
            if (auto_dct && dct_start) begin
                lat = rand_lat ? int'($urandom_range(1, 100)) : 70;
                repeat (lat) @(posedge clock);
                #1;
                mcount++;
                if (mcount % BPF == 0) fq.push_back(1'b1);
                model_done = 1'b1;
                @(posedge clock); #1;
                model_done = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] d, input int gap);
        int n = 0;
        repeat (gap) begin wr_valid = 1'b0; @(posedge clock); #1; end
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge clock);
        while (!wr_ready && n < 2000) begin @(negedge clock); n++; end
        if (!wr_ready) chk("wr_ready_timeout", 32'(wr_ready), 32'h1);
        @(posedge clock); #1;
        wr_valid = 1'b0;
    endtask

    // k is the byte index within the frame; it fixes buffer and address.
    task automatic send_bytes(input int k0, input int n, input int base, input int maxgap);
        for (int i = 0; i < n; i++) begin
            int k = k0 + i;
            bit sel = bit'((k / 64) % 2);
            logic [7:0] d = 8'(base + i);
            wq.push_back({sel ? 2'b10 : 2'b01, 6'(k % 64), d});
            if (k % 64 == 63) lq.push_back(sel);
            send_byte(d, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    task automatic pulse_done();
        manual_done = 1'b1;
        @(posedge clock); #1;
        manual_done = 1'b0;
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        @(posedge clock); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_blocks_done(input int target);
        int n = 0;
        while (blocks_done != CW'(target) && n < 5000) begin @(negedge clock); n++; end
        chk("blocks_done_final", 32'(blocks_done), 32'(target));
        @(posedge clock); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        int l0;
        // Reset values
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_buf_we", 32'(buf_we), 0);
        chk("rst_buf_waddr", 32'(buf_waddr), 0);
        chk("rst_dct_start", 32'(dct_start), 0);
        chk("rst_dct_buf_sel", 32'(dct_buf_sel), 0);
        chk("rst_counters", 32'({blocks_written, blocks_done}), 0);
        chk("rst_frame_done_busy", 32'({frame_done, busy}), 0);
        @(posedge clock); #1;
        reset = 1'b0;

        // dct_done in IDLE is ignored
        pulse_done();
        @(negedge clock);
        chk("idle_done_blocks_done", 32'(blocks_done), 0);
        chk("idle_done_busy", 32'(busy), 0);
        @(posedge clock); #1;

        // Frame 1: manual DCT, covers first launch, stall and frame end
        pulse_frame_start();
        @(negedge clock);
        chk("run_busy", 32'(busy), 1);
        chk("run_wr_ready", 32'(wr_ready), 1);
        @(posedge clock); #1;
        pulse_done();   // no DCT outstanding
        @(negedge clock);
        chk("spurious_done_bd", 32'(blocks_done), 0);
        @(posedge clock); #1;
        send_bytes(0, 10, 0, 0);
        pulse_frame_start();   // ignored in RUN
        @(negedge clock);
        chk("fs_in_run_busy", 32'(busy), 1);
        @(posedge clock); #1;
        send_bytes(10, 54, 10, 0);
        @(negedge clock);
        chk("blk0_dct_start_n1", 32'(dct_start), 0);
        chk("blk0_blocks_written", 32'(blocks_written), 1);
        @(negedge clock);
        chk("blk0_dct_start_n2", 32'(dct_start), 1);
        chk("blk0_dct_buf_sel", 32'(dct_buf_sel), 0);
        chk("blk0_wr_ready", 32'(wr_ready), 1);
        @(posedge clock); #1;
        send_bytes(64, 64, 64, 0);
        @(negedge clock);
        chk("stall_wr_ready", 32'(wr_ready), 0);
        chk("stall_blocks_written", 32'(blocks_written), 2);
        @(posedge clock); #1;
        wr_valid = 1'b1; wr_data = 8'hEE;
        idle(3);
        wr_valid = 1'b0;
        pulse_done();
        @(negedge clock);
        chk("free_wr_ready", 32'(wr_ready), 1);
        chk("free_blocks_done", 32'(blocks_done), 1);
        chk("free_dct_start_n1", 32'(dct_start), 0);
        @(negedge clock);
        chk("free_dct_start_n2", 32'(dct_start), 1);
        chk("free_dct_buf_sel", 32'(dct_buf_sel), 1);
        @(posedge clock); #1;
        send_bytes(128, 64, 128, 0);
        @(negedge clock);
        chk("frame_full_wr_ready", 32'(wr_ready), 0);
        chk("frame_full_bw", 32'(blocks_written), 3);
        @(posedge clock); #1;
        pulse_done();
        idle(3);
        fq.push_back(1'b1);
        pulse_done();
        @(negedge clock);
        chk("end_frame_done", 32'(frame_done), 1);
        chk("end_busy", 32'(busy), 0);
        chk("end_blocks_done", 32'(blocks_done), 3);
        @(posedge clock); #1;

        // Frame 2: 70-cycle DCT model, continuous wr_valid
        pulse_frame_start();
        @(negedge clock);
        chk("restart_counters", 32'({blocks_written, blocks_done}), 0);
        @(posedge clock); #1;
        auto_dct = 1'b1; rand_lat = 1'b0;
        l0 = launches;
        send_bytes(0, 192, 8'h40, 0);
        @(negedge clock);
        chk("f2_wr_ready_after_192", 32'(wr_ready), 0);
        chk("f2_blocks_written", 32'(blocks_written), 3);
        @(posedge clock); #1;
        wait_blocks_done(3);
        chk("f2_busy", 32'(busy), 0);
        chk("f2_launch_count", 32'(launches - l0), 3);
        auto_dct = 1'b0;
        idle(2);

        // Frame 3: reset at byte 30 of the third block
        pulse_frame_start();
        send_bytes(0, 64, 8'hA0, 0);
        idle(2);
        pulse_done();
        send_bytes(64, 64, 8'hE0, 0);
        idle(3);
        chk("pre_reset_dct_buf_sel", 32'(dct_buf_sel), 1);
        send_bytes(128, 30, 8'h20, 0);
        wq.delete(); lq.delete();
        reset = 1'b1; wr_valid = 1'b1; wr_data = 8'h55;
        #2;
        chk("mid_rst_wr_ready", 32'(wr_ready), 0);
        chk("mid_rst_buf_we", 32'(buf_we), 0);
        chk("mid_rst_buf_waddr", 32'(buf_waddr), 0);
        chk("mid_rst_dct_buf_sel", 32'(dct_buf_sel), 0);
        chk("mid_rst_counters", 32'({blocks_written, blocks_done}), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        @(posedge clock); #1;
        reset = 1'b0; wr_valid = 1'b0;
        pulse_done();   // stale completion of the abandoned DCT
        @(negedge clock);
        chk("stale_done_bd", 32'(blocks_done), 0);
        @(posedge clock); #1;
        pulse_frame_start();
        send_bytes(0, 64, 8'h11, 0);
        idle(3);

        // Frame 4: random wr_valid gaps and random DCT latency
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        pulse_frame_start();
        auto_dct = 1'b1; rand_lat = 1'b1;
        l0 = launches;
        send_bytes(0, 192, 8'h77, 3);
        wait_blocks_done(3);
        chk("f4_busy", 32'(busy), 0);
        chk("f4_blocks_written", 32'(blocks_written), 3);
        chk("f4_launch_count", 32'(launches - l0), 3);
        auto_dct = 1'b0;
        idle(3);

        chk("writes_left", 32'(wq.size()), 0);
        chk("launches_left", 32'(lq.size()), 0);
        chk("frame_dones_left", 32'(fq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
